// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversamples rxd, recovers bytes and emits a one-cycle rdata_ready
// strobe per good frame; a bad stop bit sets the sticky ferr flag.
module uart_rx_byte #(
  parameter int unsigned CLK_PER_HALF_BIT = 520
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rdata_ready,
  output logic       ferr,
  output logic       busy
);

  localparam int unsigned H  = CLK_PER_HALF_BIT;
  localparam int unsigned B  = 2 * H;
  localparam int unsigned CW = $clog2(B);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            rxd_m;
  logic            rxd_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Frame FSM with registered outputs; the strobe is cleared every cycle unless set below.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rdata       <= '0;
      rdata_ready <= 1'b0;
      ferr        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rdata_ready <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(H - 1)) begin
            cnt <= '0;
            idx <= '0;
            if (!rxd_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(B - 1)) begin
            cnt        <= '0;
            shift[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught in IDLE.
          if (cnt == CW'(B - 1)) begin
            cnt <= '0;
            if (rxd_s) begin
              rdata       <= shift;
              rdata_ready <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLK_PER_HALF_BIT=4: timing, back-to-back frames,
// glitch rejection, framing error, mid-frame reset and a rising-edge latching consumer.
module tb_uart_rx_byte;

  localparam int unsigned H = 4;
  localparam int unsigned B = 2 * H;
  // Raw fall -> 2 sync flops -> IDLE detect edge, then H to mid start and 9B to mid stop.
  localparam int unsigned STROBE_DELAY = 3 + H + 9 * B;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_pulse_cyc = 0;
  int ready_cycles = 0;
  int dbl = 0;
  int p0;
  int q0;
  logic busy_at_pulse = 1'b1;
  logic prev_ready = 1'b0;
  logic [7:0] core_q[$];

  uart_rx_byte #(.CLK_PER_HALF_BIT(H)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (rxd),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core-side model: latch rdata on each rising edge of rdata_ready.
  always @(negedge clk) begin
    if (rdata_ready) begin
      ready_cycles++;
      last_pulse_cyc = cyc;
      busy_at_pulse  = busy;
      if (!prev_ready) core_q.push_back(rdata);
      else dbl++;
    end
    prev_ready = rdata_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive frame bits LSB first ({stop, data, start}), B cycles each, from a negedge.
  task automatic send_frame(input logic [9:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd = fr[i];
      if (i == 0) fall_cyc = cyc;
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_ready", 32'(rdata_ready), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    idle(20);

    // Single byte 0x55 with strobe timing
    p0 = ready_cycles;
    send_frame({1'b1, 8'h55, 1'b0}, 10);
    idle(4);
    check("b55_pulses", 32'(ready_cycles - p0), 32'd1);
    check("b55_timing", 32'(last_pulse_cyc - fall_cyc), 32'(STROBE_DELAY));
    check("b55_rdata", 32'(rdata), 32'h55);
    check("b55_ferr", 32'(ferr), 32'h0);
    check("b55_busy_at_strobe", 32'(busy_at_pulse), 32'h0);
    check("b55_busy_after", 32'(busy), 32'h0);

    // Back-to-back 0xA5, 0x3C with no idle gap
    p0 = ready_cycles;
    q0 = core_q.size();
    send_frame({1'b1, 8'hA5, 1'b0}, 10);
    send_frame({1'b1, 8'h3C, 1'b0}, 10);
    idle(4);
    check("b2b_pulses", 32'(ready_cycles - p0), 32'd2);
    check("b2b_first", 32'(core_q[q0]), 32'hA5);
    check("b2b_second", 32'(core_q[q0 + 1]), 32'h3C);
    check("b2b_no_double", 32'(dbl), 32'd0);
    check("b2b_rdata", 32'(rdata), 32'h3C);

    // Glitch shorter than half a bit
    p0 = ready_cycles;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'h1);
    repeat (12) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_strobe", 32'(ready_cycles - p0), 32'd0);
    check("glitch_rdata", 32'(rdata), 32'h3C);

    // Framing error: 0x0F with stop bit 0, line held low, then recovery with 0x81
    p0 = ready_cycles;
    send_frame({1'b0, 8'h0F, 1'b0}, 10);
    repeat (30) @(negedge clk);
    check("ferr_set", 32'(ferr), 32'h1);
    check("ferr_busy_while_low", 32'(busy), 32'h1);
    check("ferr_no_strobe", 32'(ready_cycles - p0), 32'd0);
    check("ferr_rdata_held", 32'(rdata), 32'h3C);
    idle(20);
    check("ferr_busy_released", 32'(busy), 32'h0);
    p0 = ready_cycles;
    send_frame({1'b1, 8'h81, 1'b0}, 10);
    idle(4);
    check("b81_pulses", 32'(ready_cycles - p0), 32'd1);
    check("b81_rdata", 32'(rdata), 32'h81);
    check("b81_ferr_sticky", 32'(ferr), 32'h1);

    // Reset during data bit 4 of 0xF0
    p0 = ready_cycles;
    send_frame({1'b1, 8'hF0, 1'b0}, 5);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("mrst_rdata", 32'(rdata), 32'h00);
    check("mrst_ferr", 32'(ferr), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_no_strobe", 32'(ready_cycles - p0), 32'd0);
    send_frame({1'b1, 8'h12, 1'b0}, 10);
    idle(4);
    check("b12_pulses", 32'(ready_cycles - p0), 32'd1);
    check("b12_rdata", 32'(rdata), 32'h12);

    // Core handshake: three bytes latched in order, once each
    core_q.delete();
    p0 = ready_cycles;
    send_frame({1'b1, 8'h01, 1'b0}, 10);
    send_frame({1'b1, 8'h02, 1'b0}, 10);
    send_frame({1'b1, 8'h03, 1'b0}, 10);
    idle(4);
    check("core_count", 32'(core_q.size()), 32'd3);
    check("core_0", 32'(core_q[0]), 32'h01);
    check("core_1", 32'(core_q[1]), 32'h02);
    check("core_2", 32'(core_q[2]), 32'h03);
    check("core_pulses", 32'(ready_cycles - p0), 32'd3);
    check("core_no_double", 32'(dbl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver that sits directly upstream of the CPU core's input path.
- Oversamples the asynchronous serial line rxd, recovers 8N1 frames and presents each byte on rdata with a one-cycle rdata_ready strobe.
- The core's byte buffer latches rdata when it sees rdata_ready rising, so the strobe must fall between bytes.
- Flags framing errors on ferr.

Parameters:
CLK_PER_HALF_BIT, 520, clk cycles per half UART bit (full bit = 2*CLK_PER_HALF_BIT); must be >= 2

Ports:
clk  input  1  system clock
rstn  input  1  reset; synchronous, active-low, sampled on posedge clk
rxd  input  1  asynchronous serial line, idle high
rdata  output  8  last correctly received byte
rdata_ready  output  1  one-cycle strobe: rdata is valid and new
ferr  output  1  sticky framing-error flag
busy  output  1  high while a frame is being received (any state except IDLE)

Behaviour:
- Reset is synchronous, active-low, on clk. While rstn=0:
  - rdata=8'h00, rdata_ready=0, ferr=0, busy=0.
  - State=IDLE, counters=0.
  - Both synchronizer flops = 1.
  - Reset mid-frame abandons the frame with no strobe and no error.
- Input sync: rxd passes through a 2-flop synchronizer; rxd_s is the second flop. All decisions use rxd_s only.
- Constants: H = CLK_PER_HALF_BIT, B = 2*H. A single cycle counter cnt is used, sized for B-1.
- IDLE:
  - busy=0.
  - If rxd_s==0: go to START, cnt<=0.
- START:
  - cnt increments each cycle.
  - When cnt==H-1 (mid start bit): if rxd_s==0, go to DATA with cnt<=0 and bit index idx<=0.
  - Otherwise it is a glitch: return to IDLE, with no output change.
- DATA:
  - cnt increments.
  - When cnt==B-1: shift rxd_s into bit idx of the shift register (LSB first), cnt<=0, idx<=idx+1.
  - After bit 7 is sampled, go to STOP.
- STOP:
  - When cnt==B-1 (mid stop bit), sample rxd_s.
  - If 1: on the next edge rdata<=shift, rdata_ready<=1 for exactly one cycle, go to IDLE.
  - If 0: ferr<=1, rdata unchanged, no strobe, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxd_s==1, then go to IDLE. This prevents a stuck-low line from being decoded as repeated 0x00 frames.
- Latency and timing, with the synchronized falling edge of the start bit at cycle t0:
  - Start is confirmed at t0+H.
  - Data bit i is sampled at t0+H+(i+1)*B.
  - The stop bit is sampled at t0+H+9*B.
  - rdata_ready is high in the cycle after that sample.
  - Add 2 cycles for the synchronizer relative to raw rxd.
- Back-to-back frames:
  - A start bit immediately following the stop bit must be accepted.
  - IDLE is re-entered about H cycles before the nominal stop-bit end, so the next falling edge is detected in IDLE.
- ferr:
  - Sticky; cleared only by reset.
  - Subsequent good bytes still strobe normally.
- rdata holds its value between strobes.
- rdata_ready is never high for two consecutive cycles.
- Arithmetic:
  - cnt wraps only by explicit clear; never free-runs in IDLE/WAIT_HIGH.
  - idx is 3 bits plus the terminal condition at bit 7.

Test Plan:
- CLK_PER_HALF_BIT=4 (B=8). Drive 0x55 (rxd high 20 cycles, start, 01010101 LSB first, stop 1) -> exactly one rdata_ready pulse at t0+H+9B+1; rdata=0x55, ferr=0, busy falls with the strobe.
- Back-to-back 0xA5 then 0x3C with zero idle gap after the first stop bit -> two single-cycle pulses, rdata=0xA5 then 0x3C, rdata_ready low between them.
- Glitch: rxd low for 2 cycles (<H) then high -> returns to IDLE, no strobe, rdata unchanged, busy high only briefly.
- Framing error: 0x0F with stop bit 0, line then held low 30 cycles, then high -> no strobe, ferr=1, no further frames decoded while low. Then send 0x81 -> strobe, rdata=0x81, ferr remains 1.
- Reset mid-frame: assert rstn=0 during data bit 4 of 0xF0 while the bench holds rxd high; release -> all outputs 0, no strobe. Next byte 0x12 -> rdata=0x12 with one strobe.
- Core handshake: feed 3 bytes 0x01,0x02,0x03 into a model that latches on rdata_ready rising -> model buffer holds 01,02,03 in order, with no duplicate latches.
